sgb_rom_arbiter: RTL and testbench

SGB_ROM_ARBITER -- requirements
Module: sgb_rom_arbiter

---
 rtl/sgb_rom_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_sgb_rom_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sgb_rom_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sgb_rom_arbiter
// Shares one 16-bit memory port between ROM download writes, GB ROM reads
// (through a one-word cache) and savestate reads.
// Revision : 1.0
// ============================================================================
module sgb_rom_arbiter #(
    parameter int ADDR_W = 23
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              dl_wr,
    input  logic [ADDR_W-1:0] dl_addr,
    input  logic [15:0]       dl_data,
    output logic              dl_wait,
    input  logic              cart_download,
    input  logic              rom_rd,
    input  logic [ADDR_W-1:0] rom_addr,
    output logic [7:0]        rom_di,
    output logic              gb_ready,
    input  logic              ss_req,
    input  logic [ADDR_W-1:0] ss_addr,
    output logic [15:0]       ss_rdata,
    output logic              ss_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-2:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata
);

    localparam int c_WA = ADDR_W - 1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_DL_WR = 2'd1;
    localparam logic [1:0] c_GB_RD = 2'd2;
    localparam logic [1:0] c_SS_RD = 2'd3;

    logic [1:0]      r_state;
    logic [1:0]      w_next;
    logic            w_grant_gb;
    logic            w_grant_ss;

    logic            r_dl_full;
    logic [c_WA-1:0] r_dl_addr;
    logic [15:0]     r_dl_data;

    logic            r_valid;
    logic [c_WA-1:0] r_tag;
    logic [15:0]     r_data;

    logic            r_ss_pend;
    logic [c_WA-1:0] r_ss_addr;
    logic [15:0]     r_ss_rdata;
    logic            r_ss_ack;

    logic            r_last_gb;
    logic            r_cd_d;
    logic [c_WA-1:0] r_mem_addr;

    logic [c_WA-1:0] w_rom_word;
    logic [c_WA-1:0] w_ss_word;
    logic            w_hit;
    logic            w_gb_miss;
    logic            w_ss_want;
    logic            w_unused_bits;

    assign w_rom_word    = rom_addr[ADDR_W-1:1];
    assign w_hit         = r_valid && (r_tag == w_rom_word);
    assign w_gb_miss     = rom_rd && !w_hit;
    // A fresh ss_req competes in the same cycle it arrives, before it reaches the slot.
    assign w_ss_want     = r_ss_pend || ss_req;
    assign w_ss_word     = r_ss_pend ? r_ss_addr : ss_addr[ADDR_W-1:1];
    assign w_unused_bits = ^{dl_addr[0], ss_addr[0]};

    assign gb_ready  = rom_rd && w_hit;
    assign rom_di    = !gb_ready ? 8'h00 : (rom_addr[0] ? r_data[15:8] : r_data[7:0]);
    assign dl_wait   = r_dl_full;
    assign ss_rdata  = r_ss_rdata;
    assign ss_ack    = r_ss_ack;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_dl_data;

    always_ff @(posedge clk or negedge reset_n) begin : p_state
        if (!reset_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin : p_next
        w_next     = r_state;
        w_grant_gb = 1'b0;
        w_grant_ss = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (r_dl_full) begin
                    w_next = c_DL_WR;
                end else if (!cart_download) begin
                    if (w_gb_miss && w_ss_want) begin
                        w_grant_ss = r_last_gb;
                        w_grant_gb = !r_last_gb;
                    end else begin
                        w_grant_gb = w_gb_miss;
                        w_grant_ss = w_ss_want;
                    end
                    if (w_grant_gb) begin
                        w_next = c_GB_RD;
                    end else if (w_grant_ss) begin
                        w_next = c_SS_RD;
                    end
                end
            end
            default: begin
                if (mem_ack) begin
                    w_next = c_IDLE;
                end
            end
        endcase
    end

    always_comb begin : p_out
        mem_req = (r_state != c_IDLE);
        mem_we  = (r_state == c_DL_WR);
    end

    always_ff @(posedge clk or negedge reset_n) begin : p_data
        if (!reset_n) begin
            r_dl_full  <= 1'b0;
            r_dl_addr  <= '0;
            r_dl_data  <= 16'h0000;
            r_valid    <= 1'b0;
            r_tag      <= '0;
            r_data     <= 16'h0000;
            r_ss_pend  <= 1'b0;
            r_ss_addr  <= '0;
            r_ss_rdata <= 16'h0000;
            r_ss_ack   <= 1'b0;
            r_last_gb  <= 1'b0;
            r_cd_d     <= 1'b0;
            r_mem_addr <= '0;
        end else begin
            r_cd_d   <= cart_download;
            r_ss_ack <= (r_state == c_SS_RD) && mem_ack;

            if (dl_wr && !r_dl_full) begin
                r_dl_full <= 1'b1;
                r_dl_addr <= dl_addr[ADDR_W-1:1];
                r_dl_data <= dl_data;
            end
            if ((r_state == c_DL_WR) && mem_ack) begin
                r_dl_full <= 1'b0;
            end

            if (ss_req && !r_ss_pend) begin
                r_ss_pend <= 1'b1;
                r_ss_addr <= ss_addr[ADDR_W-1:1];
            end
            if ((r_state == c_SS_RD) && mem_ack) begin
                r_ss_pend  <= 1'b0;
                r_ss_rdata <= mem_rdata;
            end

            // The request address is frozen at grant time and held until the ack.
            if (r_state == c_IDLE) begin
                if (r_dl_full) begin
                    r_mem_addr <= r_dl_addr;
                end else if (w_grant_gb) begin
                    r_mem_addr <= w_rom_word;
                end else if (w_grant_ss) begin
                    r_mem_addr <= w_ss_word;
                end
            end
            if (w_grant_gb) begin
                r_last_gb <= 1'b1;
            end else if (w_grant_ss) begin
                r_last_gb <= 1'b0;
            end

            if ((r_state == c_GB_RD) && mem_ack) begin
                r_valid <= 1'b1;
                r_tag   <= r_mem_addr;
                r_data  <= mem_rdata;
            end
            // Invalidation wins over a fill completing in the same cycle.
            if ((cart_download && !r_cd_d) ||
                ((r_state == c_DL_WR) && mem_ack && (r_mem_addr == r_tag))) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sgb_rom_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sgb_rom_arbiter
// Self-checking bench with a memory responder and transaction scoreboard.
// Revision : 1.0
// ============================================================================
module tb_sgb_rom_arbiter;

    localparam int ADDR_W = 23;
    localparam int WA     = ADDR_W - 1;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              dl_wr = 1'b0;
    logic [ADDR_W-1:0] dl_addr = '0;
    logic [15:0]       dl_data = '0;
    logic              dl_wait;
    logic              cart_download = 1'b0;
    logic              rom_rd = 1'b0;
    logic [ADDR_W-1:0] rom_addr = '0;
    logic [7:0]        rom_di;
    logic              gb_ready;
    logic              ss_req = 1'b0;
    logic [ADDR_W-1:0] ss_addr = '0;
    logic [15:0]       ss_rdata;
    logic              ss_ack;
    logic              mem_req;
    logic              mem_we;
    logic [WA-1:0]     mem_addr;
    logic [15:0]       mem_wdata;
    logic              mem_ack = 1'b0;
    logic [15:0]       mem_rdata = '0;

    typedef struct packed {
        logic          we;
        logic [WA-1:0] addr;
        logic [15:0]   wdata;
    } txn_t;

    txn_t        exp_q[$];
    txn_t        obs_q[$];
    logic [15:0] ss_exp_q[$];
    logic [15:0] mem_model [logic [WA-1:0]];
    txn_t        resp_t;

    int n_checks   = 0;
    int n_fail     = 0;
    int ack_delay  = 1;
    int wait_cnt   = 0;
    int stray_cnt  = 0;
    int stray_done = 0;

    sgb_rom_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data), .dl_wait(dl_wait),
        .cart_download(cart_download), .rom_rd(rom_rd), .rom_addr(rom_addr),
        .rom_di(rom_di), .gb_ready(gb_ready),
        .ss_req(ss_req), .ss_addr(ss_addr), .ss_rdata(ss_rdata), .ss_ack(ss_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model_rd(input logic [WA-1:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return {a[7:0] ^ 8'hC3, a[7:0]};
    endfunction

    // Memory responder: acks each request after ack_delay waiting cycles.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (stray_cnt != stray_done) begin
                mem_ack   = 1'b1;
                mem_rdata = 16'hDEAD;
                stray_done++;
            end else if (mem_req) begin
                if (wait_cnt >= ack_delay) begin
                    resp_t.we    = mem_we;
                    resp_t.addr  = mem_addr;
                    resp_t.wdata = mem_we ? mem_wdata : 16'h0000;
                    obs_q.push_back(resp_t);
                    mem_rdata = model_rd(mem_addr);
                    if (mem_we) mem_model[mem_addr] = mem_wdata;
                    mem_ack  = 1'b1;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        repeat (3) step();
        reset_n = 1'b1;
        step();
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        n_checks++; if (dl_wait !== 1'b0) begin n_fail++; $display("FAIL reset_dl_wait: got %b want 0", dl_wait); end
        n_checks++; if ({gb_ready, rom_di} !== 9'h000) begin n_fail++; $display("FAIL reset_gb: got %b/%h want 0/00", gb_ready, rom_di); end
        n_checks++; if ({ss_ack, ss_rdata} !== 17'h0) begin n_fail++; $display("FAIL reset_ss: got %b/%h want 0/0000", ss_ack, ss_rdata); end
    endtask

    task automatic test_dl_write();
        int   wait_cycles = 0;
        int   first_wait = -1;
        int   first_req = -1;
        int   bad = 0;
        txn_t e, o;
        ack_delay = 3;
        dl_addr = 23'h000100; dl_data = 16'hBEEF; dl_wr = 1'b1;
        exp_q.push_back({1'b1, 22'h000080, 16'hBEEF});
        step();
        dl_wr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (dl_wait) begin
                wait_cycles++;
                if (first_wait < 0) first_wait = i;
            end
            if (mem_req) begin
                if (first_req < 0) first_req = i;
                if (mem_we !== 1'b1 || mem_addr !== 22'h000080 || mem_wdata !== 16'hBEEF) bad++;
            end
            // A second write while the buffer is busy must be dropped.
            if (i == 1) begin
                dl_wr = 1'b1; dl_addr = 23'h000200; dl_data = 16'h1111;
            end else begin
                dl_wr = 1'b0;
            end
            step();
        end
        n_checks++; if (wait_cycles != 5) begin n_fail++; $display("FAIL dl_wait_len: got %0d want 5", wait_cycles); end
        n_checks++; if (first_req != first_wait + 1) begin n_fail++; $display("FAIL dl_req_latency: got %0d want %0d", first_req, first_wait + 1); end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL dl_req_stable: got %0d bad cycles want 0", bad); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL dl_txn: got none want %h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL dl_txn: got %h want %h", o, e); end end
        end
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL dl_extra_txn: got %0d want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_gb_read();
        logic got = 1'b0;
        txn_t e, o;
        ack_delay = 1;
        mem_model[22'h0000A8] = 16'h3CA5;
        rom_rd = 1'b1; rom_addr = 23'h000151;
        exp_q.push_back({1'b0, 22'h0000A8, 16'h0000});
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            got = gb_ready;
        end
        n_checks++; if (got !== 1'b1 || rom_di !== 8'h3C) begin n_fail++; $display("FAIL gb_hi_byte: got %b/%h want 1/3c", got, rom_di); end
        rom_addr = 23'h000150;
        #1;
        n_checks++; if (rom_di !== 8'hA5) begin n_fail++; $display("FAIL gb_lo_byte: got %h want a5", rom_di); end
        repeat (4) step();
        n_checks++; if (gb_ready !== 1'b1) begin n_fail++; $display("FAIL gb_hold: got %b want 1", gb_ready); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL gb_txn: got none want %h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL gb_txn: got %h want %h", o, e); end end
        end
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL gb_refetch: got %0d extra want 0", obs_q.size()); obs_q.delete(); end
        rom_rd = 1'b0;
        #1;
        n_checks++; if ({gb_ready, rom_di} !== 9'h000) begin n_fail++; $display("FAIL gb_idle: got %b/%h want 0/00", gb_ready, rom_di); end
    endtask

    task automatic test_ss_priority();
        int          acks = 0;
        logic        gb_seen = 1'b0;
        logic [15:0] got_data = 16'h0000;
        logic [15:0] want;
        logic [15:0] gb_word;
        txn_t        e, o;
        ack_delay = 2;
        rom_rd = 1'b1; rom_addr = 23'h000300;
        ss_req = 1'b1; ss_addr = 23'h000201;
        exp_q.push_back({1'b0, 22'h000100, 16'h0000});
        exp_q.push_back({1'b0, 22'h000180, 16'h0000});
        ss_exp_q.push_back(model_rd(22'h000100));
        step();
        ss_req = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (ss_ack) begin acks++; got_data = ss_rdata; end
            if (gb_ready) gb_seen = 1'b1;
            step();
        end
        want = ss_exp_q.pop_front();
        n_checks++; if (acks != 1) begin n_fail++; $display("FAIL ss_ack_pulses: got %0d want 1", acks); end
        n_checks++; if (got_data !== want) begin n_fail++; $display("FAIL ss_rdata: got %h want %h", got_data, want); end
        gb_word = model_rd(22'h000180);
        n_checks++; if (gb_seen !== 1'b1 || rom_di !== gb_word[7:0]) begin n_fail++; $display("FAIL ss_then_gb: got %b/%h want 1/%h", gb_seen, rom_di, gb_word[7:0]); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL ss_order: got none want %h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL ss_order: got %h want %h", o, e); end end
        end
        obs_q.delete();
        rom_rd = 1'b0;
    endtask

    task automatic test_dl_invalidate();
        logic got = 1'b0;
        txn_t e, o;
        ack_delay = 1;
        rom_rd = 1'b1; rom_addr = 23'h000150;
        exp_q.push_back({1'b0, 22'h0000A8, 16'h0000});
        for (int i = 0; i < 20 && !got; i++) begin step(); got = gb_ready; end
        n_checks++; if (got !== 1'b1 || rom_di !== 8'hA5) begin n_fail++; $display("FAIL inv_prefill: got %b/%h want 1/a5", got, rom_di); end
        rom_rd = 1'b0;
        dl_addr = 23'h000150; dl_data = 16'h7E81; dl_wr = 1'b1;
        exp_q.push_back({1'b1, 22'h0000A8, 16'h7E81});
        step();
        dl_wr = 1'b0;
        for (int i = 0; i < 20 && dl_wait; i++) step();
        step();
        rom_rd = 1'b1;
        #1;
        n_checks++; if (gb_ready !== 1'b0) begin n_fail++; $display("FAIL inv_drop: got %b want 0", gb_ready); end
        exp_q.push_back({1'b0, 22'h0000A8, 16'h0000});
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin step(); got = gb_ready; end
        n_checks++; if (got !== 1'b1 || rom_di !== 8'h81) begin n_fail++; $display("FAIL inv_refetch: got %b/%h want 1/81", got, rom_di); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL inv_txn: got none want %h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL inv_txn: got %h want %h", o, e); end end
        end
        obs_q.delete();
        rom_rd = 1'b0;
    endtask

    task automatic test_cart_download();
        int   reqs = 0;
        logic got = 1'b0;
        txn_t e, o;
        cart_download = 1'b1;
        step(); step();
        rom_rd = 1'b1; rom_addr = 23'h000150;
        #1;
        n_checks++; if (gb_ready !== 1'b0) begin n_fail++; $display("FAIL cd_invalidate: got %b want 0", gb_ready); end
        for (int i = 0; i < 8; i++) begin step(); if (mem_req) reqs++; end
        n_checks++; if (reqs != 0) begin n_fail++; $display("FAIL cd_block_gb: got %0d req cycles want 0", reqs); end
        cart_download = 1'b0;
        exp_q.push_back({1'b0, 22'h0000A8, 16'h0000});
        for (int i = 0; i < 20 && !got; i++) begin step(); got = gb_ready; end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL cd_resume: got none want %h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL cd_resume: got %h want %h", o, e); end end
        end
        obs_q.delete();
        rom_rd = 1'b0;
    endtask

    task automatic test_reset_mid();
        int   reqs = 0;
        logic seen = 1'b0;
        ack_delay = 10;
        rom_rd = 1'b1; rom_addr = 23'h000401;
        for (int i = 0; i < 20 && !seen; i++) begin step(); seen = mem_req; end
        n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL mid_req_start: got %b want 1", seen); end
        @(negedge clk);
        rom_addr = 23'h000150;
        reset_n = 1'b0;
        #1;
        n_checks++; if ({mem_req, mem_we} !== 2'b00) begin n_fail++; $display("FAIL mid_mem: got %b want 00", {mem_req, mem_we}); end
        n_checks++; if ({gb_ready, rom_di} !== 9'h000) begin n_fail++; $display("FAIL mid_gb: got %b/%h want 0/00", gb_ready, rom_di); end
        n_checks++; if ({dl_wait, ss_ack, ss_rdata} !== 18'h0) begin n_fail++; $display("FAIL mid_ss_dl: got %b/%b/%h want 0/0/0000", dl_wait, ss_ack, ss_rdata); end
        rom_rd = 1'b0;
        repeat (2) step();
        @(negedge clk);
        reset_n = 1'b1;
        stray_cnt++;
        for (int i = 0; i < 6; i++) begin step(); if (mem_req) reqs++; end
        n_checks++; if (reqs != 0) begin n_fail++; $display("FAIL stray_ack_req: got %0d req cycles want 0", reqs); end
        rom_rd = 1'b1; rom_addr = 23'h000401;
        #1;
        n_checks++; if (gb_ready !== 1'b0) begin n_fail++; $display("FAIL stray_ack_fill: got %b want 0", gb_ready); end
        rom_rd = 1'b0;
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL mid_lost_txn: got %0d txns want 0", obs_q.size()); end
    endtask

    initial begin
        test_reset();
        test_dl_write();
        test_gb_read();
        test_ss_priority();
        test_dl_invalidate();
        test_cart_download();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
